// File: rtl/mem_arbiter.sv
// Shares one main-memory port between the I-cache and D-cache line engines.
// D-side wins ties; the I-side is forced through after STARVE_LIMIT straight D wins.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 128,
    parameter int BEATS        = 4,
    parameter int STARVE_LIMIT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ic_req_valid,
    input  logic [ADDR_WIDTH-1:0] ic_req_addr,
    output logic                  ic_req_ready,
    output logic                  ic_resp_valid,
    output logic [DATA_WIDTH-1:0] ic_resp_data,
    input  logic                  dc_req_valid,
    input  logic                  dc_req_rnw,
    input  logic [ADDR_WIDTH-1:0] dc_req_addr,
    output logic                  dc_req_ready,
    input  logic                  dc_wdata_valid,
    input  logic [DATA_WIDTH-1:0] dc_wdata,
    output logic                  dc_wdata_ready,
    output logic                  dc_resp_valid,
    output logic [DATA_WIDTH-1:0] dc_resp_data,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_rnw,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic                  mem_wdata_valid,
    input  logic                  mem_wdata_ready,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data,
    output logic                  err
);

    localparam int CNT_W = $clog2(BEATS);
    localparam int OFF_W = $clog2(BEATS * DATA_WIDTH / 8);
    localparam int STV_W = $clog2(STARVE_LIMIT + 2);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~((ADDR_WIDTH'(1) << OFF_W) - ADDR_WIDTH'(1));
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BEATS - 1);
    localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

    state_t                state, state_next;
    logic                  owner_ic, owner_ic_next;
    logic                  rnw_q, rnw_next;
    logic [ADDR_WIDTH-1:0] addr_q, addr_next;
    logic [CNT_W-1:0]      beat_cnt, beat_cnt_next;
    logic [STV_W-1:0]      starve_cnt, starve_cnt_next;
    logic                  grant_ic;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner_ic   <= 1'b0;
            rnw_q      <= 1'b0;
            addr_q     <= '0;
            beat_cnt   <= '0;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            owner_ic   <= owner_ic_next;
            rnw_q      <= rnw_next;
            addr_q     <= addr_next;
            beat_cnt   <= beat_cnt_next;
            starve_cnt <= starve_cnt_next;
        end
    end

    always_comb begin
        state_next      = state;
        owner_ic_next   = owner_ic;
        rnw_next        = rnw_q;
        addr_next       = addr_q;
        beat_cnt_next   = beat_cnt;
        starve_cnt_next = starve_cnt;
        grant_ic        = 1'b0;
        ic_req_ready    = 1'b0;
        ic_resp_valid   = 1'b0;
        ic_resp_data    = '0;
        dc_req_ready    = 1'b0;
        dc_wdata_ready  = 1'b0;
        dc_resp_valid   = 1'b0;
        dc_resp_data    = '0;
        mem_req_valid   = 1'b0;
        mem_req_rnw     = 1'b0;
        mem_req_addr    = '0;
        mem_wdata_valid = 1'b0;
        mem_wdata       = '0;
        err             = 1'b0;

        case (state)
            IDLE: begin
                grant_ic = ic_req_valid && (!dc_req_valid || starve_cnt == STARVE_MAX);
                if (ic_req_valid || dc_req_valid) begin
                    owner_ic_next = grant_ic;
                    rnw_next      = grant_ic ? 1'b1 : dc_req_rnw;
                    addr_next     = (grant_ic ? ic_req_addr : dc_req_addr) & LINE_MASK;
                    // Starvation only accrues when the I-side actually lost a tie.
                    if (grant_ic)
                        starve_cnt_next = '0;
                    else if (ic_req_valid && starve_cnt != STARVE_MAX)
                        starve_cnt_next = starve_cnt + STV_W'(1);
                    state_next = CMD;
                end
            end
            CMD: begin
                mem_req_valid = 1'b1;
                mem_req_rnw   = rnw_q;
                mem_req_addr  = addr_q;
                if (mem_req_ready) begin
                    ic_req_ready  = owner_ic;
                    dc_req_ready  = !owner_ic;
                    beat_cnt_next = '0;
                    state_next    = rnw_q ? RDATA : WDATA;
                end
            end
            WDATA: begin
                mem_wdata_valid = dc_wdata_valid;
                mem_wdata       = dc_wdata;
                dc_wdata_ready  = mem_wdata_ready;
                if (dc_wdata_valid && mem_wdata_ready) begin
                    beat_cnt_next = beat_cnt + CNT_W'(1);
                    if (beat_cnt == LAST_BEAT)
                        state_next = IDLE;
                end
            end
            RDATA: begin
                if (mem_resp_valid) begin
                    ic_resp_valid = owner_ic;
                    dc_resp_valid = !owner_ic;
                    ic_resp_data  = owner_ic ? mem_resp_data : '0;
                    dc_resp_data  = owner_ic ? '0 : mem_resp_data;
                    beat_cnt_next = beat_cnt + CNT_W'(1);
                    if (beat_cnt == LAST_BEAT)
                        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        err = mem_resp_valid && (state != RDATA);

        // A reset cycle must not leak a beat or handshake of the aborted transfer.
        if (reset) begin
            ic_req_ready    = 1'b0;
            ic_resp_valid   = 1'b0;
            ic_resp_data    = '0;
            dc_req_ready    = 1'b0;
            dc_wdata_ready  = 1'b0;
            dc_resp_valid   = 1'b0;
            dc_resp_data    = '0;
            mem_req_valid   = 1'b0;
            mem_req_rnw     = 1'b0;
            mem_req_addr    = '0;
            mem_wdata_valid = 1'b0;
            mem_wdata       = '0;
            err             = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected events, a negedge
// monitor pops and compares each command, beat, write handshake and err pulse.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NB = 4;
    localparam int SL = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ic_req_valid = 1'b0;
    logic [AW-1:0] ic_req_addr = '0;
    logic          ic_req_ready;
    logic          ic_resp_valid;
    logic [DW-1:0] ic_resp_data;
    logic          dc_req_valid = 1'b0;
    logic          dc_req_rnw = 1'b0;
    logic [AW-1:0] dc_req_addr = '0;
    logic          dc_req_ready;
    logic          dc_wdata_valid = 1'b0;
    logic [DW-1:0] dc_wdata = '0;
    logic          dc_wdata_ready;
    logic          dc_resp_valid;
    logic [DW-1:0] dc_resp_data;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b0;
    logic          mem_req_rnw;
    logic [AW-1:0] mem_req_addr;
    logic          mem_wdata_valid;
    logic          mem_wdata_ready = 1'b0;
    logic [DW-1:0] mem_wdata;
    logic          mem_resp_valid = 1'b0;
    logic [DW-1:0] mem_resp_data = '0;
    logic          err;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEATS(NB), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
        .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
        .dc_req_valid(dc_req_valid), .dc_req_rnw(dc_req_rnw), .dc_req_addr(dc_req_addr),
        .dc_req_ready(dc_req_ready), .dc_wdata_valid(dc_wdata_valid), .dc_wdata(dc_wdata),
        .dc_wdata_ready(dc_wdata_ready), .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rnw(mem_req_rnw),
        .mem_req_addr(mem_req_addr), .mem_wdata_valid(mem_wdata_valid),
        .mem_wdata_ready(mem_wdata_ready), .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .err(err)
    );

    always #5 clk = ~clk;

    typedef enum logic [2:0] {EV_ERR, EV_CMD, EV_IC, EV_DC, EV_WB} kind_t;
    typedef struct packed {
        kind_t       kind;
        logic [63:0] data;
    } ev_t;

    ev_t sb[$];
    int  checks = 0;
    int  errors = 0;

    function automatic logic [DW-1:0] beatData(input int tag, input int idx);
        return 32'hA500_0000 + DW'(tag * 256 + idx);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic pushEv(input kind_t k, input logic [63:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        sb.push_back(e);
    endtask

    // Command events carry {ic_req_ready, dc_req_ready, rnw, addr} so the owner is checked too.
    task automatic pushCmd(input logic is_ic, input logic rnw, input logic [AW-1:0] addr);
        pushEv(EV_CMD, {29'b0, is_ic, !is_ic, rnw, addr});
    endtask

    task automatic pushResp(input logic is_ic, input int tag);
        for (int i = 0; i < NB; i++)
            pushEv(is_ic ? EV_IC : EV_DC, {32'b0, beatData(tag, i)});
    endtask

    task automatic popCheck(input kind_t k, input logic [63:0] d);
        ev_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_event: got kind %0d data %0h expected none", k, d);
        end else begin
            e = sb.pop_front();
            checkOutput($sformatf("sb_kind(exp %0d)", e.kind), 64'(k), 64'(e.kind));
            checkOutput($sformatf("sb_data(kind %0d)", e.kind), d, e.data);
        end
    endtask

    // Monitor: every DUT-presented event in a cycle, in a fixed order.
    always @(negedge clk) begin
        if (err)
            popCheck(EV_ERR, 64'd0);
        if (mem_req_valid && mem_req_ready)
            popCheck(EV_CMD, {29'b0, ic_req_ready, dc_req_ready, mem_req_rnw, mem_req_addr});
        if (ic_resp_valid)
            popCheck(EV_IC, {32'b0, ic_resp_data});
        if (dc_resp_valid)
            popCheck(EV_DC, {32'b0, dc_resp_data});
        if (mem_wdata_valid && mem_wdata_ready)
            popCheck(EV_WB, {31'b0, dc_wdata_ready, mem_wdata});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitAccept(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ic_req_ready || dc_req_ready)
                seen = 1'b1;
        end
        checkOutput(name, 64'(seen), 64'd1);
        tick();
    endtask

    task automatic driveBeats(input int tag, input int n);
        for (int i = 0; i < n; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = beatData(tag, i);
            tick();
        end
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
    endtask

    task automatic applyStimulus();
        bit order_ic [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        repeat (3) tick();
        @(negedge clk);
        checkOutput("reset_outputs",
                    {ic_req_ready, dc_req_ready, ic_resp_valid, dc_resp_valid, mem_req_valid,
                     mem_wdata_valid, dc_wdata_ready, err, mem_req_addr}, 64'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("idle_after_reset", {mem_req_valid, mem_req_rnw, mem_req_addr, mem_wdata}, 64'd0);
        tick();

        // IC line read alone
        mem_req_ready = 1'b1;
        ic_req_valid  = 1'b1;
        ic_req_addr   = 32'h0000_1234;
        pushCmd(1'b1, 1'b1, 32'h0000_1230);
        pushResp(1'b1, 1);
        @(negedge clk);
        checkOutput("s1_no_req_same_cycle", 64'(mem_req_valid), 64'd0);
        tick();
        @(negedge clk);
        checkOutput("s1_req_next_cycle", {ic_req_ready, mem_req_valid}, 64'd3);
        tick();
        ic_req_valid = 1'b0;
        driveBeats(1, NB);
        @(negedge clk);
        checkOutput("s1_idle_after", {mem_req_valid, ic_resp_valid, dc_resp_valid}, 64'd0);
        tick();

        // DC line write with command stall and toggling write ready
        mem_req_ready = 1'b0;
        dc_req_valid  = 1'b1;
        dc_req_rnw    = 1'b0;
        dc_req_addr   = 32'h0000_0080;
        pushCmd(1'b0, 1'b0, 32'h0000_0080);
        for (int i = 0; i < NB; i++)
            pushEv(EV_WB, {31'b0, 1'b1, beatData(2, i)});
        tick();
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            checkOutput("s2_cmd_hold", {mem_req_valid, mem_req_rnw, dc_req_ready, mem_req_addr},
                        {29'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0080});
            tick();
        end
        mem_req_ready = 1'b1;
        waitAccept("s2_accept");
        dc_req_valid   = 1'b0;
        dc_wdata_valid = 1'b1;
        for (int i = 0; i < NB; i++) begin
            dc_wdata        = beatData(2, i);
            mem_wdata_ready = 1'b0;
            tick();
            mem_wdata_ready = 1'b1;
            tick();
        end
        dc_wdata_valid  = 1'b0;
        mem_wdata_ready = 1'b0;
        @(negedge clk);
        checkOutput("s2_idle_after", {mem_wdata_valid, dc_wdata_ready, mem_req_valid}, 64'd0);
        tick();

        // Both requesters continuously valid: DC, DC, IC, DC, DC, IC
        mem_req_ready = 1'b1;
        ic_req_valid  = 1'b1;
        ic_req_addr   = 32'h0000_3008;
        dc_req_valid  = 1'b1;
        dc_req_rnw    = 1'b1;
        dc_req_addr   = 32'h0000_4014;
        for (int t = 0; t < 6; t++) begin
            pushCmd(order_ic[t], 1'b1, order_ic[t] ? 32'h0000_3000 : 32'h0000_4010);
            pushResp(order_ic[t], 10 + t);
            waitAccept($sformatf("s3_accept%0d", t));
            if (t == 5) begin
                ic_req_valid = 1'b0;
                dc_req_valid = 1'b0;
            end
            driveBeats(10 + t, NB);
        end

        // Stray read beat during CMD
        mem_req_ready = 1'b0;
        dc_req_valid  = 1'b1;
        dc_req_rnw    = 1'b1;
        dc_req_addr   = 32'h0000_0100;
        pushEv(EV_ERR, 64'd0);
        pushCmd(1'b0, 1'b1, 32'h0000_0100);
        pushResp(1'b0, 20);
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h0000_0BAD;
        @(negedge clk);
        checkOutput("s4_err_pulse", {err, ic_resp_valid, dc_resp_valid}, 64'd4);
        tick();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        checkOutput("s4_err_one_cycle", 64'(err), 64'd0);
        tick();
        mem_req_ready = 1'b1;
        waitAccept("s4_accept");
        dc_req_valid = 1'b0;
        driveBeats(20, NB);

        // Reset after two of four read beats, IC request kept pending
        ic_req_valid = 1'b1;
        ic_req_addr  = 32'h0000_5004;
        pushCmd(1'b1, 1'b1, 32'h0000_5000);
        pushEv(EV_IC, {32'b0, beatData(30, 0)});
        pushEv(EV_IC, {32'b0, beatData(30, 1)});
        waitAccept("s5_accept");
        driveBeats(30, 2);
        reset          = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = beatData(30, 2);
        @(negedge clk);
        checkOutput("s5_reset_gates", {ic_resp_valid, dc_resp_valid, err, mem_req_valid}, 64'd0);
        tick();
        reset          = 1'b0;
        mem_resp_valid = 1'b0;
        pushCmd(1'b1, 1'b1, 32'h0000_5000);
        pushResp(1'b1, 31);
        @(negedge clk);
        checkOutput("s5_idle_after_reset", {mem_req_valid, ic_resp_valid, err}, 64'd0);
        tick();
        @(negedge clk);
        checkOutput("s5_regrant", 64'(mem_req_valid), 64'd1);
        tick();
        ic_req_valid = 1'b0;
        driveBeats(31, NB);

        // Back-to-back: DC read then pending IC
        dc_req_valid = 1'b1;
        dc_req_rnw   = 1'b1;
        dc_req_addr  = 32'h0000_0640;
        pushCmd(1'b0, 1'b1, 32'h0000_0640);
        pushResp(1'b0, 40);
        waitAccept("s6_accept");
        dc_req_valid = 1'b0;
        ic_req_valid = 1'b1;
        ic_req_addr  = 32'h0000_0700;
        pushCmd(1'b1, 1'b1, 32'h0000_0700);
        pushResp(1'b1, 41);
        driveBeats(40, NB);
        @(negedge clk);
        checkOutput("s6_gap_m1", 64'(mem_req_valid), 64'd0);
        tick();
        @(negedge clk);
        checkOutput("s6_req_m2", 64'(mem_req_valid), 64'd1);
        tick();
        ic_req_valid = 1'b0;
        driveBeats(41, NB);
        repeat (3) tick();
    endtask

    initial begin
        applyStimulus();
        checkOutput("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
